// File: rtl/wsmemory.sv
// wsmemory: parametrised single-port word memory with req/ack handshake
// and a configurable number of wait states per access.
module wsmemory #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4096,
    parameter int WAIT   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_C = 4'(WAIT);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              mem_wr;
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    assign in_range = ({1'b0, addr_q} < DEPTH_L);
    assign idx      = addr_q[IDX_W-1:0];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        mem_wr  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d    = we;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = WAIT_C;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_DONE;
                    if (in_range) begin
                        err_d = 1'b0;
                        if (we_q) mem_wr = 1'b1;
                        else      rdata_d = mem[idx];
                    end else begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        ack_d  = (state_d == S_DONE);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    // Array has no reset; an async reset drops state to IDLE so mem_wr cannot fire.
    always_ff @(posedge clk) begin
        if (mem_wr) mem[idx] <= wdata_q;
    end

    assign rdata = rdata_q;
    assign ack   = ack_q;
    assign busy  = busy_q;
    assign err   = err_q;

endmodule

// File: tb/tb_wsmemory.sv
// tb_wsmemory: directed checks of wsmemory (WAIT=2 16-bit instance and
// WAIT=0 32-bit instance).
module tb_wsmemory;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_a, we_a;
    logic [15:0] addr_a, wdata_a, rdata_a;
    logic        ack_a, busy_a, err_a;

    logic        req_b, we_b;
    logic [9:0]  addr_b;
    logic [31:0] wdata_b, rdata_b;
    logic        ack_b, busy_b, err_b;

    int          n_chk = 0;
    int          n_fail = 0;
    int          lat, bc, na;
    logic [31:0] rd;
    logic        e;

    always #5 clk = ~clk;

    wsmemory #(.DATA_W(16), .ADDR_W(16), .DEPTH(4096), .WAIT(2)) u_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .rdata(rdata_a), .ack(ack_a), .busy(busy_a),
        .err(err_a)
    );

    wsmemory #(.DATA_W(32), .ADDR_W(10), .DEPTH(1024), .WAIT(0)) u_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .rdata(rdata_b), .ack(ack_b), .busy(busy_b),
        .err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one request on the chosen instance and watch 10 edges after capture.
    task automatic acc(input bit b, input logic w, input logic [15:0] a,
                       input logic [31:0] d, output int lt, output int bcnt,
                       output int nack, output logic [31:0] rdv,
                       output logic ev);
        if (b) begin
            req_b = 1'b1; we_b = w; addr_b = a[9:0]; wdata_b = d;
        end else begin
            req_a = 1'b1; we_a = w; addr_a = a; wdata_a = d[15:0];
        end
        @(posedge clk); #1;
        req_a = 1'b0; we_a = ~w; addr_a = 16'hFFFF; wdata_a = '0;
        req_b = 1'b0; we_b = ~w; addr_b = '1;       wdata_b = '0;
        lt = 0; nack = 0; rdv = '0; ev = 1'b0;
        bcnt = (b ? busy_b : busy_a) ? 1 : 0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (b ? busy_b : busy_a) bcnt++;
            if (b ? ack_b : ack_a) begin
                nack++;
                if (lt == 0) lt = i;
                rdv = b ? rdata_b : {16'h0, rdata_a};
                ev  = b ? err_b : err_a;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;

        for (int i = 0; i < 3; i++) begin
            req_a = (i % 2 == 0); we_a = 1'b1;
            addr_a = 16'h0040; wdata_a = 16'h1111;
            @(posedge clk); #1;
            check("rst_ack", 32'(ack_a), 32'h0);
            check("rst_busy", 32'(busy_a), 32'h0);
            check("rst_err", 32'(err_a), 32'h0);
            check("rst_rdata", 32'(rdata_a), 32'h0);
        end
        req_a = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;

        acc(0, 1, 16'h0010, 32'hBEEF, lat, bc, na, rd, e);
        check("wr_lat", 32'(lat), 32'd3);
        check("wr_nack", 32'(na), 32'd1);
        check("wr_busy", 32'(bc), 32'd4);
        check("wr_err", 32'(e), 32'h0);

        acc(0, 0, 16'h0010, 32'h0, lat, bc, na, rd, e);
        check("rd_lat", 32'(lat), 32'd3);
        check("rd_data", rd, 32'hBEEF);
        check("rd_err", 32'(e), 32'h0);
        check("rd_hold", 32'(rdata_a), 32'hBEEF);

        acc(0, 1, 16'h0FFF, 32'h1234, lat, bc, na, rd, e);
        acc(0, 1, 16'h0000, 32'h0A0A, lat, bc, na, rd, e);
        acc(0, 0, 16'h0FFF, 32'h0, lat, bc, na, rd, e);
        check("top_data", rd, 32'h1234);
        check("top_err", 32'(e), 32'h0);

        acc(0, 1, 16'h1000, 32'h5555, lat, bc, na, rd, e);
        check("oor_wr_err", 32'(e), 32'h1);
        acc(0, 0, 16'h0000, 32'h0, lat, bc, na, rd, e);
        check("no_alias", rd, 32'h0A0A);
        acc(0, 0, 16'h0FFF, 32'h0, lat, bc, na, rd, e);
        check("oor_keep", rd, 32'h1234);
        acc(0, 0, 16'h1000, 32'h0, lat, bc, na, rd, e);
        check("oor_rd_data", rd, 32'h0);
        check("oor_rd_err", 32'(e), 32'h1);
        check("oor_lat", 32'(lat), 32'd3);

        // Held req: captures on edges 1,6,11,16,21 -> five acks.
        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0010;
        na = 0;
        for (int i = 1; i <= 29; i++) begin
            @(posedge clk); #1;
            if (i == 21) req_a = 1'b0;
            if (ack_a) begin
                na++;
                check("b2b_data", 32'(rdata_a), 32'hBEEF);
            end
        end
        check("b2b_acks", 32'(na), 32'd5);

        req_a = 1'b1; we_a = 1'b0; addr_a = 16'h0FFF;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk); #1;
        req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0010; wdata_a = 16'h7777;
        @(posedge clk); #1;
        req_a = 1'b0;
        na = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ack_a) begin
                na++;
                check("pulse_data", 32'(rdata_a), 32'h1234);
            end
        end
        check("pulse_acks", 32'(na), 32'd1);
        acc(0, 0, 16'h0010, 32'h0, lat, bc, na, rd, e);
        check("pulse_nowr", rd, 32'hBEEF);

        acc(0, 1, 16'h0020, 32'hAAAA, lat, bc, na, rd, e);
        req_a = 1'b1; we_a = 1'b1; addr_a = 16'h0020; wdata_a = 16'h5555;
        @(posedge clk); #1;
        req_a = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("abort_busy", 32'(busy_a), 32'h0);
        na = 0;
        for (int i = 0; i < 2; i++) begin
            req_a = (i == 0); wdata_a = 16'h1111;
            @(posedge clk); #1;
            if (ack_a) na++;
        end
        req_a = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ack_a) na++;
        end
        check("abort_noack", 32'(na), 32'd0);
        acc(0, 0, 16'h0020, 32'h0, lat, bc, na, rd, e);
        check("abort_mem", rd, 32'hAAAA);

        acc(1, 1, 16'h03FF, 32'hDEADBEEF, lat, bc, na, rd, e);
        check("w0_wr_lat", 32'(lat), 32'd1);
        check("w0_wr_busy", 32'(bc), 32'd2);
        check("w0_wr_nack", 32'(na), 32'd1);
        acc(1, 0, 16'h03FF, 32'h0, lat, bc, na, rd, e);
        check("w0_rd_lat", 32'(lat), 32'd1);
        check("w0_rd_data", rd, 32'hDEADBEEF);
        check("w0_rd_err", 32'(e), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
